// File: rtl/tutor_count_sequencer_pkg.sv
// Shared definitions for the TutorVHDL counter/latch sequencer.
//   state_t      : sequencer states
//   TUTOR_WIDTH  : default counter/data width of the datapath
//   DP_*_RST     : idle/reset levels of the datapath control outputs
package tutor_pkg;

    localparam int unsigned TUTOR_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_CAPTURE,
        ST_SHOW,
        ST_FINISH
    } state_t;

    localparam logic DP_CLR_RST = 1'b1;
    localparam logic DP_OE_RST  = 1'b1;
    localparam logic DP_DIR_RST = 1'b1;

endpackage

// File: rtl/tutor_count_sequencer_prescaler.sv
// Rate prescaler: DIV_W-bit down-counter with load and freeze.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : reload the counter with 'reload' (wins over freeze)
//   freeze     : hold the current count
//   reload     : reload value; a tick occurs every reload+1 enabled cycles
//   tick_next  : the count for the coming cycle is zero (tick in that cycle)
module tutor_prescaler
#(
    parameter int unsigned DIV_W = 8
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             freeze,
    input  logic [DIV_W-1:0] reload,
    output logic             tick_next
);

    logic [DIV_W-1:0] count_q;
    logic [DIV_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = reload;
        end else if (!freeze) begin
            count_d = (count_q == '0) ? reload : count_q - DIV_W'(1);
        end
    end

    // Looks one cycle ahead so the caller can register its CE output.
    assign tick_next = (count_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tutor_count_sequencer.sv
// Sequencer for the TutorVHDL counter/latch datapath.
// Accepts one command (start value, limit, direction, rate, dwell) via START,
// then loads the datapath, counts to the limit, latches and shows the result.
// The count is tracked in a shadow register; the datapath Q is never read.
//   CLK, CLR_N         : clock, asynchronous active-low reset
//   START, ABORT, PAUSE: command request, cancel, run freeze
//   LOAD_VAL, LIMIT, UP, DIV, DWELL : command fields, captured on START
//   OE_EN              : requested output enable (registered to DP_OE)
//   BUSY, DONE, ABORTED: status; DONE/ABORTED are one-cycle pulses
//   DP_*               : registered datapath controls and load value
module tutor_count_sequencer
    import tutor_pkg::*;
#(
    parameter int unsigned WIDTH   = TUTOR_WIDTH,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DWELL_W = 8
)
(
    input  logic               CLK,
    input  logic               CLR_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic               PAUSE,
    input  logic [WIDTH-1:0]   LOAD_VAL,
    input  logic [WIDTH-1:0]   LIMIT,
    input  logic               UP,
    input  logic [DIV_W-1:0]   DIV,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic               OE_EN,
    output logic               BUSY,
    output logic               DONE,
    output logic               ABORTED,
    output logic               DP_CLR,
    output logic               DP_CE,
    output logic               DP_LOAD,
    output logic               DP_DIR,
    output logic               DP_SEL,
    output logic               DP_OE,
    output logic               DP_LE,
    output logic [WIDTH-1:0]   DP_DATA
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d, step;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic               up_q, up_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               pause_q;
    logic               aborted_d;
    logic               run_entry, pre_freeze, tick_next;
    logic               busy_d, done_d, ce_d, load_d, dir_d, sel_d, le_d;
    logic [WIDTH-1:0]   data_d;

    assign step = up_q ? shadow_q + WIDTH'(1) : shadow_q - WIDTH'(1);

    // Next state and captured command fields.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        limit_d   = limit_q;
        up_d      = up_q;
        div_d     = div_q;
        dwell_d   = dwell_q;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d  = ST_LOAD;
                    shadow_d = LOAD_VAL;
                    limit_d  = LIMIT;
                    up_d     = UP;
                    div_d    = DIV;
                    dwell_d  = DWELL;
                end
            end
            ST_LOAD:    state_d = (shadow_q == limit_q) ? ST_CAPTURE : ST_RUN;
            ST_RUN: begin
                // DP_CE high this cycle means the datapath steps on this edge.
                if (DP_CE) begin
                    shadow_d = step;
                    if (step == limit_q) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: state_d = (dwell_q != '0) ? ST_SHOW : ST_FINISH;
            ST_SHOW: begin
                dwell_d = dwell_q - DWELL_W'(1);
                if (dwell_q == DWELL_W'(1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE && ABORT) begin
            state_d   = ST_IDLE;
            aborted_d = 1'b1;
        end
    end

    // Prescaler restarts on RUN entry and only advances on unpaused RUN cycles.
    assign run_entry  = (state_d == ST_RUN) && (state_q != ST_RUN);
    assign pre_freeze = (state_q != ST_RUN) || pause_q;

    tutor_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk       (CLK),
        .rst_n     (CLR_N),
        .load      (run_entry),
        .freeze    (pre_freeze),
        .reload    (div_q),
        .tick_next (tick_next)
    );

    // Output values for the coming cycle, decoded from the next state so
    // every output can be registered without adding latency.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_FINISH);
        load_d = (state_d == ST_LOAD);
        le_d   = (state_d == ST_CAPTURE);
        sel_d  = (state_d == ST_SHOW);
        ce_d   = 1'b0;
        dir_d  = DP_DIR_RST;
        data_d = '0;
        if (state_d == ST_LOAD) begin
            ce_d   = 1'b1;
            dir_d  = UP;
            data_d = LOAD_VAL;
        end else if (state_d == ST_RUN) begin
            ce_d  = tick_next && !PAUSE;
            dir_d = up_q;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            limit_q  <= '0;
            up_q     <= 1'b0;
            div_q    <= '0;
            dwell_q  <= '0;
            pause_q  <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ABORTED  <= 1'b0;
            DP_CLR   <= DP_CLR_RST;
            DP_CE    <= 1'b0;
            DP_LOAD  <= 1'b0;
            DP_DIR   <= DP_DIR_RST;
            DP_SEL   <= 1'b0;
            DP_OE    <= DP_OE_RST;
            DP_LE    <= 1'b0;
            DP_DATA  <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            limit_q  <= limit_d;
            up_q     <= up_d;
            div_q    <= div_d;
            dwell_q  <= dwell_d;
            pause_q  <= PAUSE;
            BUSY     <= busy_d;
            DONE     <= done_d;
            ABORTED  <= aborted_d;
            DP_CLR   <= 1'b0;
            DP_CE    <= ce_d;
            DP_LOAD  <= load_d;
            DP_DIR   <= dir_d;
            DP_SEL   <= sel_d;
            DP_OE    <= OE_EN;
            DP_LE    <= le_d;
            DP_DATA  <= data_d;
        end
    end

endmodule

// File: tb/tb_tutor_count_sequencer.sv
module tb_tutor_count_sequencer;

    logic       CLK = 1'b0;
    logic       CLR_N, START, ABORT, PAUSE, UP, OE_EN;
    logic [3:0] LOAD_VAL, LIMIT, DP_DATA;
    logic [7:0] DIV, DWELL;
    logic       BUSY, DONE, ABORTED, DP_CLR, DP_CE, DP_LOAD, DP_DIR, DP_SEL, DP_OE, DP_LE;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    tutor_count_sequencer #(.WIDTH(4), .DIV_W(8), .DWELL_W(8)) dut (
        .CLK(CLK), .CLR_N(CLR_N), .START(START), .ABORT(ABORT), .PAUSE(PAUSE),
        .LOAD_VAL(LOAD_VAL), .LIMIT(LIMIT), .UP(UP), .DIV(DIV), .DWELL(DWELL),
        .OE_EN(OE_EN), .BUSY(BUSY), .DONE(DONE), .ABORTED(ABORTED),
        .DP_CLR(DP_CLR), .DP_CE(DP_CE), .DP_LOAD(DP_LOAD), .DP_DIR(DP_DIR),
        .DP_SEL(DP_SEL), .DP_OE(DP_OE), .DP_LE(DP_LE), .DP_DATA(DP_DATA)
    );

    // Behavioural model of the external counter/latch datapath.
    logic [3:0] cnt_m = '0;
    logic [3:0] lat_m = '0;
    logic [3:0] q_m;
    always @(posedge CLK) begin
        if (DP_CLR) cnt_m <= '0;
        else if (DP_CE) cnt_m <= DP_LOAD ? DP_DATA : (DP_DIR ? cnt_m + 4'd1 : cnt_m - 4'd1);
        if (DP_LE) lat_m <= cnt_m;
    end
    assign q_m = DP_SEL ? lat_m : cnt_m;

    // Per-cycle records of one command (bit c = cycle c after the START edge).
    logic [63:0] ce_v, ld_v, le_v, sel_v, done_v, busy_v, abt_v;
    int          run_ce, done_at;
    logic [3:0]  q_show, data_c1;
    logic        dir_c2;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic run_cmd(input logic [3:0] lv, input logic [3:0] lim, input logic up,
                           input logic [7:0] div, input logic [7:0] dwell, input int ncyc,
                           input int pause_from, input int pause_len,
                           input int abort_at, input int restart_at);
        ce_v = '0; ld_v = '0; le_v = '0; sel_v = '0; done_v = '0; busy_v = '0; abt_v = '0;
        run_ce = 0; done_at = -1; q_show = '0; data_c1 = '0; dir_c2 = 1'b1;
        LOAD_VAL = lv; LIMIT = lim; UP = up; DIV = div; DWELL = dwell;
        START = 1'b1;
        ABORT = (abort_at == 0);
        PAUSE = (pause_len > 0) && (pause_from == 0);
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge CLK); #1;
            ce_v[c] = DP_CE; ld_v[c] = DP_LOAD; le_v[c] = DP_LE; sel_v[c] = DP_SEL;
            done_v[c] = DONE; busy_v[c] = BUSY; abt_v[c] = ABORTED;
            if (DP_CE && !DP_LOAD) run_ce++;
            if (DONE && done_at < 0) done_at = c;
            if (DP_SEL) q_show = q_m;
            if (c == 1) data_c1 = DP_DATA;
            if (c == 2) dir_c2 = DP_DIR;
            // Command inputs change after acceptance; they must have no effect.
            LOAD_VAL = ~lv; LIMIT = ~lim; UP = ~up; DIV = div + 8'd3; DWELL = dwell + 8'd1;
            START = (c == restart_at);
            ABORT = (c == abort_at);
            PAUSE = (c >= pause_from) && (c < pause_from + pause_len);
        end
        START = 1'b0; ABORT = 1'b0; PAUSE = 1'b0;
    endtask

    initial begin
        CLR_N = 1'b0; START = 1'b0; ABORT = 1'b0; PAUSE = 1'b0; UP = 1'b0; OE_EN = 1'b1;
        LOAD_VAL = '0; LIMIT = '0; DIV = '0; DWELL = '0;

        // Reset values and release
        #12;
        check("rst_clr",  DP_CLR, 1);
        check("rst_oe",   DP_OE, 1);
        check("rst_dir",  DP_DIR, 1);
        check("rst_busy", BUSY, 0);
        check("rst_ce",   DP_CE, 0);
        @(negedge CLK); CLR_N = 1'b1;
        @(posedge CLK); #1;
        check("rel_clr", DP_CLR, 0);
        OE_EN = 1'b0;
        @(posedge CLK); #1;
        check("oe_delay0", DP_OE, 0);
        OE_EN = 1'b1;
        @(posedge CLK); #1;
        check("oe_delay1", DP_OE, 1);

        // 7 -> 9 up, DIV=0, DWELL=2, ignored START while busy at cycle 3
        run_cmd(4'd7, 4'd9, 1'b1, 8'd0, 8'd2, 12, -1, 0, -1, 3);
        check("t2_load",  ld_v,   64'h2);
        check("t2_data",  data_c1, 4'd7);
        check("t2_ce",    ce_v,   64'hE);
        check("t2_le",    le_v,   64'h10);
        check("t2_sel",   sel_v,  64'h60);
        check("t2_done",  done_v, 64'h80);
        check("t2_busy",  busy_v, 64'hFE);
        check("t2_qshow", q_show, 4'd9);
        check("t2_abt",   abt_v,  64'h0);

        // Wrap 14 -> 1 up, DIV=1
        run_cmd(4'd14, 4'd1, 1'b1, 8'd1, 8'd0, 14, -1, 0, -1, -1);
        check("t3u_ce",    ce_v,   64'hAA);
        check("t3u_le",    le_v,   64'h100);
        check("t3u_sel",   sel_v,  64'h0);
        check("t3u_done",  done_v, 64'h200);
        check("t3u_latch", lat_m,  4'd1);

        // Wrap 14 -> 1 down, DIV=1
        run_cmd(4'd14, 4'd1, 1'b0, 8'd1, 8'd0, 34, -1, 0, -1, -1);
        check("t3d_runce", run_ce,  13);
        check("t3d_done",  done_at, 29);
        check("t3d_dir",   dir_c2,  0);
        check("t3d_latch", lat_m,   4'd1);

        // LOAD_VAL == LIMIT, DWELL=3, START together with ABORT in IDLE
        run_cmd(4'd5, 4'd5, 1'b1, 8'd0, 8'd3, 10, -1, 0, 0, -1);
        check("t4_ce",    ce_v,   64'h2);
        check("t4_le",    le_v,   64'h4);
        check("t4_sel",   sel_v,  64'h38);
        check("t4_done",  done_v, 64'h40);
        check("t4_busy",  busy_v, 64'h7E);
        check("t4_qshow", q_show, 4'd5);

        // DIV=2, without and with a 4-cycle PAUSE
        run_cmd(4'd0, 4'd3, 1'b1, 8'd2, 8'd0, 16, -1, 0, -1, -1);
        check("t5a_ce",   ce_v,    64'h492);
        check("t5a_done", done_at, 12);
        run_cmd(4'd0, 4'd3, 1'b1, 8'd2, 8'd0, 20, 5, 4, -1, -1);
        check("t5b_ce",    ce_v,    64'h4812);
        check("t5b_runce", run_ce,  3);
        check("t5b_done",  done_at, 16);
        check("t5b_latch", lat_m,   4'd3);

        // ABORT during SHOW
        run_cmd(4'd2, 4'd3, 1'b1, 8'd0, 8'd5, 12, -1, 0, 5, -1);
        check("t6_abt",  abt_v,  64'h40);
        check("t6_done", done_v, 64'h0);
        check("t6_busy", busy_v, 64'h3E);
        check("t6_sel",  sel_v,  64'h30);

        // CLR_N pulse in RUN
        run_cmd(4'd0, 4'd10, 1'b0, 8'd0, 8'd0, 4, -1, 0, -1, -1);
        check("t7_busy_pre", BUSY, 1);
        #2 CLR_N = 1'b0;
        #1;
        check("t7_clr",  DP_CLR, 1);
        check("t7_busy", BUSY, 0);
        check("t7_ce",   DP_CE, 0);
        check("t7_dir",  DP_DIR, 1);
        @(posedge CLK); #1;
        check("t7_done", DONE, 0);
        check("t7_abt",  ABORTED, 0);
        @(negedge CLK); CLR_N = 1'b1;
        @(posedge CLK); #1;
        check("t7_rel_clr",  DP_CLR, 0);
        check("t7_rel_busy", BUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
